x_stream_gen: RTL and testbench
===============================

X_STREAM_GEN -- requirements
Module: x_stream_gen

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of entries in the word holding buffer (legal 2..8).
REQ-002 SHALL have parameter IDLE_X, default 1'b0, meaning the value driven on x when no bit is being sent.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  input  1  the reset, asynchronous and active-low.
REQ-005 SHALL have port load_valid  input  1  the producer offers a word this cycle.
REQ-006 SHALL have port load_data  input  8  the word to serialize.
REQ-007 SHALL have port load_len  input  3  the number of bits to send from load_data, where 1..7 means that many bits and 0 means 8 bits.
REQ-008 SHALL have port load_ready  output  1  the buffer can accept a word this cycle.
REQ-009 SHALL have port x  output  1  the serial bit stream feeding the downstream Moore/Mealy sequence machine input.
REQ-010 SHALL have port x_valid  output  1  x carries a payload bit this cycle.
REQ-011 SHALL have port word_done  output  1  a one-cycle pulse coincident with the last bit of a word.
REQ-012 SHALL have port busy  output  1  the shifter is active or the buffer is non-empty.
REQ-013 SHALL have port bit_count  output  8  the running count of payload bits sent, modulo 256.

Function
REQ-014 SHALL accept a word on any rising edge where load_valid=1 and load_ready=1, storing {load_data, load_len} into the buffer in FIFO order.
REQ-015 SHALL drive load_ready=1 exactly when the buffer count is less than DEPTH, computed from registered count only, with no same-cycle pass-through when the buffer is full.
REQ-016 SHALL implement a shifter FSM with the states IDLE and SHIFT.
REQ-017 SHALL, in IDLE with a non-empty buffer, pop the head entry at the next edge, move to SHIFT, and present that entry's MSB-position bit (bit len-1, where len 0 means bit 7) on x with x_valid=1.
REQ-018 SHALL register x and x_valid, and SHALL have a latency from word acceptance at edge N to its first bit on x after edge N+1 when the block is idle and the buffer is empty.
REQ-019 SHALL, in SHIFT, advance one bit per clock, MSB-first, from bit len-1 down to bit 0.
REQ-020 SHALL assert word_done=1 in the same cycle that x carries bit 0 of a word.
REQ-021 SHALL, on the edge ending bit 0, pop the next word and present its first bit in the next cycle if the buffer is non-empty, giving back-to-back words with no idle cycle; otherwise it SHALL return to IDLE.
REQ-022 SHALL, on simultaneous push and pop in the same edge, perform both, leaving the buffer count unchanged.
REQ-023 SHALL, in IDLE, drive x=IDLE_X, x_valid=0 and word_done=0.
REQ-024 SHALL increment bit_count by 1 on each edge that ends a cycle with x_valid=1, wrapping from 255 to 0.
REQ-025 SHALL drive busy = (state==SHIFT) OR (buffer count > 0).

Reset
REQ-026 SHALL, on RESET=0 and independent of CLK, immediately force state=IDLE, buffer empty, x=IDLE_X, x_valid=0, word_done=0, bit_count=0, busy=0 and load_ready=1.
REQ-027 SHALL discard any word in flight or buffered when reset is asserted mid-word, with no partial bits emitted after release.
REQ-028 SHALL have its first possible acceptance on the first rising edge after RESET returns to 1.

Verification
REQ-029 Single word: push 8'hB4 with len=0 into an idle block -> x=1,0,1,1,0,1,0,0 on 8 consecutive cycles starting one cycle after acceptance, word_done only on the 8th, bit_count=8.
REQ-030 Short word: push 8'h05 with len=3 -> x=1,0,1, word_done on the 3rd bit, then x_valid=0 and x=IDLE_X.
REQ-031 Back-to-back: push 8'hFF/len 2 and then 8'h00/len 2 on consecutive cycles -> x=1,1,0,0 with no gap, and word_done on the 2nd and 4th bits.
REQ-032 Full buffer: hold load_valid=1 while the shifter is busy with DEPTH=2 -> load_ready drops after 2 buffered words, no word is lost or duplicated, and the output order matches the input order.
REQ-033 Reset mid-word: assert RESET=0 during bit 3 of 8'hAA/len 0 -> outputs take their reset values immediately, and after release x_valid stays 0 until a new push.
REQ-034 Wrap: send 32 words of len 0 -> bit_count reads 0 after the 256th bit.

Source files
------------

// File: rtl/x_stream_gen.sv
// x_stream_gen: buffers (data, len) words in a small FIFO and serializes each
// one MSB-first onto a registered bit stream feeding a sequence machine.
//
// Ports:
//   CLK         rising-edge clock
//   RESET       asynchronous active-low reset
//   load_valid  producer offers {load_data, load_len} this cycle
//   load_data   word to serialize
//   load_len    bits to send: 1..7 literal, 0 means 8
//   load_ready  buffer has room (registered, derived from buffer count)
//   x           serial bit, IDLE_X when nothing is sent
//   x_valid     x carries a payload bit
//   word_done   pulse coincident with bit 0 of a word
//   busy        shifter active or buffer non-empty
//   bit_count   payload bits sent, modulo 256
module x_stream_gen #(
  parameter int unsigned DEPTH  = 2,
  parameter logic        IDLE_X = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic [2:0] load_len,
  output logic       load_ready,
  output logic       x,
  output logic       x_valid,
  output logic       word_done,
  output logic       busy,
  output logic [7:0] bit_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] len;
  } entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  state_t           state;
  state_t           state_nxt;
  logic [7:0]       cur_data;
  logic [7:0]       cur_data_nxt;
  logic [2:0]       idx;
  logic [2:0]       idx_nxt;
  logic [2:0]       idx_dec;
  logic             x_nxt;
  logic             x_valid_nxt;
  logic             word_done_nxt;
  logic             busy_nxt;
  logic             push;
  logic             pop;
  entry_t           head;
  logic [2:0]       head_idx;

  // Pointer advance with wrap for non-power-of-two depths
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head     = mem[rd_ptr];
  // len 0 wraps to index 7, so len-1 is the MSB index for every length
  assign head_idx = head.len - 3'd1;
  assign idx_dec  = idx - 3'd1;
  assign push     = load_valid && load_ready;
  // Pop when idle, or on the edge that ends bit 0 of the current word
  assign pop      = (count != '0) && ((state == IDLE) || (idx == 3'd0));

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = SHIFT;
      SHIFT:   if ((idx == 3'd0) && (count == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    x_nxt         = IDLE_X;
    x_valid_nxt   = 1'b0;
    word_done_nxt = 1'b0;
    idx_nxt       = idx;
    cur_data_nxt  = cur_data;
    if (pop) begin
      cur_data_nxt  = head.data;
      idx_nxt       = head_idx;
      x_nxt         = head.data[head_idx];
      x_valid_nxt   = 1'b1;
      word_done_nxt = (head_idx == 3'd0);
    end else if ((state == SHIFT) && (idx != 3'd0)) begin
      idx_nxt       = idx_dec;
      x_nxt         = cur_data[idx_dec];
      x_valid_nxt   = 1'b1;
      word_done_nxt = (idx_dec == 3'd0);
    end
  end

  // Buffer occupancy
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_W'(1);
    else if (!push && pop) count_nxt = count - CNT_W'(1);
  end

  assign busy_nxt = (state_nxt == SHIFT) || (count_nxt != '0);

  // Buffer storage (contents need no reset; occupancy is tracked by count)
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{data: load_data, len: load_len};
  end

  // Registered datapath and outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cur_data   <= '0;
      idx        <= '0;
      x          <= IDLE_X;
      x_valid    <= 1'b0;
      word_done  <= 1'b0;
      bit_count  <= '0;
      load_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count      <= count_nxt;
      cur_data   <= cur_data_nxt;
      idx        <= idx_nxt;
      x          <= x_nxt;
      x_valid    <= x_valid_nxt;
      word_done  <= word_done_nxt;
      bit_count  <= bit_count + {7'd0, x_valid};
      load_ready <= (count_nxt < CNT_W'(DEPTH));
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_x_stream_gen.sv
// Bench for x_stream_gen: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_x_stream_gen;

  localparam int unsigned DEPTH  = 2;
  localparam logic        IDLE_X = 1'b0;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'd0;
  logic [2:0] load_len = 3'd0;
  logic       load_ready;
  logic       x;
  logic       x_valid;
  logic       word_done;
  logic       busy;
  logic [7:0] bit_count;

  always #5 CLK = ~CLK;

  x_stream_gen #(.DEPTH(DEPTH), .IDLE_X(IDLE_X)) dut (
    .CLK(CLK), .RESET(RESET),
    .load_valid(load_valid), .load_data(load_data), .load_len(load_len),
    .load_ready(load_ready), .x(x), .x_valid(x_valid), .word_done(word_done),
    .busy(busy), .bit_count(bit_count)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered words and remaining bits of the word on x
  logic [7:0] mq_d[$];
  logic [2:0] mq_l[$];
  bit         cur[$];
  logic       m_x = IDLE_X;
  logic       m_xv = 1'b0;
  logic       m_wd = 1'b0;
  int         m_cnt = 0;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mq_d.delete(); mq_l.delete(); cur.delete();
      m_x = IDLE_X; m_xv = 1'b0; m_wd = 1'b0; m_cnt = 0;
    end else begin
      bit acc;
      logic [7:0] d;
      int n;
      acc = load_valid && (mq_d.size() < DEPTH);
      if (m_xv) m_cnt = (m_cnt + 1) % 256;
      if (cur.size() == 0 && mq_d.size() > 0) begin
        d = mq_d.pop_front();
        n = mq_l[0] == 3'd0 ? 8 : int'(mq_l[0]);
        void'(mq_l.pop_front());
        for (int i = n - 1; i >= 0; i--) cur.push_back(d[i]);
      end
      if (cur.size() > 0) begin
        m_x = cur.pop_front(); m_xv = 1'b1; m_wd = (cur.size() == 0);
      end else begin
        m_x = IDLE_X; m_xv = 1'b0; m_wd = 1'b0;
      end
      if (acc) begin
        mq_d.push_back(load_data); mq_l.push_back(load_len);
      end
    end
  end

  // Per-cycle comparison against the model
  logic chk_en = 1'b0;
  always @(negedge CLK) begin
    if (RESET && chk_en) begin
      chk("x", 32'(x), 32'(m_x));
      chk("x_valid", 32'(x_valid), 32'(m_xv));
      chk("word_done", 32'(word_done), 32'(m_wd));
      chk("bit_count", 32'(bit_count), 32'(m_cnt));
      chk("load_ready", 32'(load_ready), 32'(mq_d.size() < DEPTH));
      chk("busy", 32'(busy), 32'(m_xv || mq_d.size() > 0));
    end
  end

  // Observer: collects the emitted stream and reassembles words
  logic [31:0] cap = '0;
  logic [7:0]  wbuf = '0;
  logic [7:0]  wout[$];
  int nbits = 0, n_wd = 0, cyc = 0, first_cyc = -1, last_cyc = -1;
  always @(negedge CLK) begin
    cyc++;
    if (RESET && x_valid) begin
      cap = {cap[30:0], x};
      wbuf = {wbuf[6:0], x};
      nbits++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (word_done) begin
        n_wd++; wout.push_back(wbuf); wbuf = '0;
      end
    end
  end

  task automatic clear_obs();
    cap = '0; wbuf = '0; wout.delete();
    nbits = 0; n_wd = 0; first_cyc = -1; last_cyc = -1;
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] l);
    @(negedge CLK);
    chk("ready_before_push", 32'(load_ready), 32'd1);
    load_valid = 1'b1; load_data = d; load_len = l;
    @(negedge CLK);
    load_valid = 1'b0;
  endtask

  logic [7:0] in_d[$];
  logic [2:0] in_l[$];
  int stalls = 0;

  // Holds load_valid high and advances data only on accepted edges
  task automatic stream();
    int t;
    @(negedge CLK);
    load_valid = 1'b1;
    for (int i = 0; i < in_d.size(); i++) begin
      load_data = in_d[i]; load_len = in_l[i];
      t = 0;
      while (!load_ready && t < 200) begin
        @(negedge CLK); t++; stalls++;
      end
      if (t >= 200) chk("stream_timeout", 32'd1, 32'd0);
      @(negedge CLK);
    end
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 3000) begin
      @(negedge CLK); t++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_x"}, 32'(x), 32'(IDLE_X));
    chk({tag, "_x_valid"}, 32'(x_valid), 32'd0);
    chk({tag, "_word_done"}, 32'(word_done), 32'd0);
    chk({tag, "_bit_count"}, 32'(bit_count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_load_ready"}, 32'(load_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [7:0] expw;
    repeat (3) @(negedge CLK);
    check_reset_values("reset");
    RESET = 1'b1;
    chk_en = 1'b1;

    // Single 8-bit word: first bit one cycle after acceptance
    clear_obs();
    push(8'hB4, 3'd0);
    chk("t1_latency_gap", 32'(x_valid), 32'd0);
    @(negedge CLK);
    chk("t1_first_valid", 32'(x_valid), 32'd1);
    chk("t1_first_bit", 32'(x), 32'd1);
    wait_idle();
    chk("t1_bits", cap, 32'h0000_00B4);
    chk("t1_nbits", 32'(nbits), 32'd8);
    chk("t1_word_done", 32'(n_wd), 32'd1);
    chk("t1_bit_count", 32'(bit_count), 32'd8);

    // Short 3-bit word
    clear_obs();
    push(8'h05, 3'd3);
    wait_idle();
    chk("t2_bits", cap, 32'h0000_0005);
    chk("t2_nbits", 32'(nbits), 32'd3);
    chk("t2_word_done", 32'(n_wd), 32'd1);
    @(negedge CLK);
    chk("t2_idle_x", 32'(x), 32'(IDLE_X));
    chk("t2_idle_valid", 32'(x_valid), 32'd0);

    // Back-to-back words with no gap
    clear_obs();
    @(negedge CLK);
    load_valid = 1'b1; load_data = 8'hFF; load_len = 3'd2;
    @(negedge CLK);
    load_data = 8'h00; load_len = 3'd2;
    @(negedge CLK);
    load_valid = 1'b0;
    wait_idle();
    chk("t3_bits", cap, 32'h0000_000C);
    chk("t3_nbits", 32'(nbits), 32'd4);
    chk("t3_word_done", 32'(n_wd), 32'd2);
    chk("t3_no_gap", 32'(last_cyc - first_cyc + 1), 32'd4);

    // Full buffer with valid held high
    clear_obs();
    in_d = '{8'hA5, 8'h3C, 8'h81, 8'h7E, 8'h12, 8'hC9};
    in_l = '{3'd0, 3'd5, 3'd1, 3'd0, 3'd4, 3'd6};
    stalls = 0;
    stream();
    wait_idle();
    chk("t4_stalled", 32'(stalls > 0), 32'd1);
    chk("t4_words", 32'(wout.size()), 32'd6);
    for (int i = 0; i < 6 && i < wout.size(); i++) begin
      n = in_l[i] == 3'd0 ? 8 : int'(in_l[i]);
      expw = in_d[i] & 8'((9'd1 << n) - 9'd1);
      chk($sformatf("t4_word%0d", i), 32'(wout[i]), 32'(expw));
    end

    // Reset during the third bit of a word
    clear_obs();
    push(8'hAA, 3'd0);
    repeat (3) @(negedge CLK);
    chk("t5_midword_valid", 32'(x_valid), 32'd1);
    #2 RESET = 1'b0;
    #1 check_reset_values("t5_async");
    @(negedge CLK);
    RESET = 1'b1;
    clear_obs();
    repeat (10) @(negedge CLK);
    chk("t5_no_residue", 32'(nbits), 32'd0);
    push(8'h0F, 3'd4);
    wait_idle();
    chk("t5_after_bits", cap, 32'h0000_000F);
    chk("t5_after_count", 32'(bit_count), 32'd4);

    // Counter wrap: 32 full words after a fresh reset
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    clear_obs();
    in_d.delete(); in_l.delete();
    for (int i = 0; i < 32; i++) begin
      in_d.push_back(8'(i * 37 + 5));
      in_l.push_back(3'd0);
    end
    stream();
    wait_idle();
    chk("t6_nbits", 32'(nbits), 32'd256);
    chk("t6_words", 32'(n_wd), 32'd32);
    chk("t6_wrap", 32'(bit_count), 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
